// File: rtl/gcd_arbiter.sv
// Round-robin arbiter/sequencer sharing one GCD core among N_REQ requesters.
// Grants one requester, latches its operands, runs the core, returns the result.
module gcd_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned W     = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*W-1:0] req_a,
    input  logic [N_REQ*W-1:0] req_b,
    output logic [N_REQ-1:0]   ack,
    output logic [N_REQ-1:0]   rsp_valid,
    output logic [W-1:0]       rsp_gcd,
    output logic               busy,
    output logic               core_start,
    output logic [W-1:0]       core_a,
    output logic [W-1:0]       core_b,
    input  logic               core_done,
    input  logic [W-1:0]       core_gcd
);

    localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [N_REQ-1:0] ONE = {{(N_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_DONE,
        WAIT_DROP
    } state_t;

    state_t        state;
    logic [PW-1:0] ptr;
    logic [PW-1:0] g;
    logic [W-1:0]  op_a;
    logic [W-1:0]  op_b;

    logic [PW-1:0] pick;
    logic [PW-1:0] scan;
    logic          found;

    // Circular scan starting at ptr; first set request bit wins.
    always_comb begin
        pick  = ptr;
        found = 1'b0;
        scan  = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            scan = PW'((32'(ptr) + k) % N_REQ);
            if (!found && req[scan]) begin
                found = 1'b1;
                pick  = scan;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            ptr        <= '0;
            g          <= '0;
            op_a       <= '0;
            op_b       <= '0;
            ack        <= '0;
            rsp_valid  <= '0;
            rsp_gcd    <= '0;
            busy       <= 1'b0;
            core_start <= 1'b0;
        end else begin
            ack        <= '0;
            rsp_valid  <= '0;
            core_start <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (found) begin
                        g          <= pick;
                        op_a       <= req_a[32'(pick)*W +: W];
                        op_b       <= req_b[32'(pick)*W +: W];
                        ack        <= ONE << pick;
                        core_start <= 1'b1;
                        busy       <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (core_done) begin
                        rsp_gcd   <= core_gcd;
                        rsp_valid <= ONE << g;
                        state     <= WAIT_DROP;
                    end
                end
                WAIT_DROP: begin
                    // The core only takes a new start once done has fallen.
                    if (!core_done) begin
                        ptr   <= (32'(g) + 1 == N_REQ) ? '0 : g + PW'(1);
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign core_a = op_a;
    assign core_b = op_b;

endmodule

// File: tb/tb_gcd_arbiter.sv
// Directed bench for gcd_arbiter with a behavioural GCD core (done held 2 cycles).
module tb_gcd_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned WD = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N*WD-1:0] req_a = '0;
    logic [N*WD-1:0] req_b = '0;
    logic [N-1:0]    ack;
    logic [N-1:0]    rsp_valid;
    logic [WD-1:0]   rsp_gcd;
    logic            busy;
    logic            core_start;
    logic [WD-1:0]   core_a;
    logic [WD-1:0]   core_b;
    logic            core_done;
    logic [WD-1:0]   core_gcd;

    gcd_arbiter #(.N_REQ(N), .W(WD)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_a(req_a), .req_b(req_b),
        .ack(ack), .rsp_valid(rsp_valid), .rsp_gcd(rsp_gcd), .busy(busy),
        .core_start(core_start), .core_a(core_a), .core_b(core_b),
        .core_done(core_done), .core_gcd(core_gcd)
    );

    always #5 clk = ~clk;

    // Behavioural core: fixed latency after start, done held two cycles.
    logic          m_busy;
    int            m_cnt;
    int            m_hold;
    logic [WD-1:0] m_a;
    logic [WD-1:0] m_b;

    function automatic logic [WD-1:0] gcd_f(input logic [WD-1:0] a, input logic [WD-1:0] b);
        logic [WD-1:0] x, y, t;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_busy <= 1'b0; m_cnt <= 0; m_hold <= 0;
            core_done <= 1'b0; core_gcd <= '0; m_a <= '0; m_b <= '0;
        end else if (m_hold != 0) begin
            m_hold <= m_hold - 1;
            if (m_hold == 1) core_done <= 1'b0;
        end else if (m_busy) begin
            if (m_cnt == 0) begin
                m_busy <= 1'b0; core_done <= 1'b1; m_hold <= 2;
                core_gcd <= gcd_f(m_a, m_b);
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end else if (core_start) begin
            m_busy <= 1'b1; m_cnt <= 3; m_a <= core_a; m_b <= core_b;
        end
    end

    int vec = 0;
    int miss = 0;
    int cyc = 0;
    int starts = 0;
    int start_clash = 0;
    int proto_err = 0;
    bit hold_req = 1'b0;
    logic prev_done = 1'b0;

    logic [N-1:0]  ack_log[$];
    int            ack_cyc[$];
    logic [N-1:0]  rsp_log[$];
    logic [WD-1:0] gcd_log[$];
    int            rsp_cyc[$];
    int            done_cyc[$];
    int            start_cyc[$];
    logic [WD-1:0] sa_log[$];
    logic [WD-1:0] sb_log[$];

    task automatic clear_logs();
        ack_log.delete(); ack_cyc.delete(); rsp_log.delete(); gcd_log.delete();
        rsp_cyc.delete(); done_cyc.delete(); start_cyc.delete();
        sa_log.delete(); sb_log.delete();
        starts = 0;
    endtask

    // Pads logs so indexing after a short run yields values that cannot match.
    task automatic pad_logs(input int n);
        while (ack_log.size() < n)   begin ack_log.push_back('x); ack_cyc.push_back(-100); end
        while (rsp_log.size() < n)   begin rsp_log.push_back('x); gcd_log.push_back('x); rsp_cyc.push_back(-100); end
        while (done_cyc.size() < n)  done_cyc.push_back(-1000);
        while (start_cyc.size() < n) begin start_cyc.push_back(-100); sa_log.push_back('x); sb_log.push_back('x); end
    endtask

    // One cycle: sample at negedge, record events, requester drops req on ack.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (ack != 0) begin ack_log.push_back(ack); ack_cyc.push_back(cyc); end
        if (rsp_valid != 0) begin rsp_log.push_back(rsp_valid); gcd_log.push_back(rsp_gcd); rsp_cyc.push_back(cyc); end
        if (core_done && !prev_done) done_cyc.push_back(cyc);
        prev_done = core_done;
        if (core_start) begin
            starts++;
            start_cyc.push_back(cyc); sa_log.push_back(core_a); sb_log.push_back(core_b);
            if (m_busy || core_done) start_clash++;
        end
        if (!$onehot0(ack) || !$onehot0(rsp_valid) || (ack & rsp_valid) != 0) proto_err++;
        if (!hold_req) req = req & ~ack;
    endtask

    task automatic run_until_rsp(input int n, input int budget);
        int k;
        k = 0;
        while (rsp_log.size() < n && k < budget) begin tick(); k++; end
    endtask

    task automatic run_until_ack(input int n, input int budget);
        int k;
        k = 0;
        while (ack_log.size() < n && k < budget) begin tick(); k++; end
    endtask

    task automatic drain();
        int k;
        k = 0;
        tick();
        while (busy && k < 100) begin tick(); k++; end
    endtask

    task automatic set_ops(input int i, input logic [WD-1:0] a, input logic [WD-1:0] b);
        req_a[i*WD +: WD] = a;
        req_b[i*WD +: WD] = b;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        vec++; if (ack !== 4'b0000)       begin miss++; $display("FAIL reset_ack: got %b expected 0000", ack); end
        vec++; if (rsp_valid !== 4'b0000) begin miss++; $display("FAIL reset_rsp_valid: got %b expected 0000", rsp_valid); end
        vec++; if (busy !== 1'b0)         begin miss++; $display("FAIL reset_busy: got %b expected 0", busy); end
        vec++; if (core_start !== 1'b0)   begin miss++; $display("FAIL reset_core_start: got %b expected 0", core_start); end
        vec++; if (rsp_gcd !== 16'd0)     begin miss++; $display("FAIL reset_rsp_gcd: got %0d expected 0", rsp_gcd); end
        vec++; if (core_a !== 16'd0 || core_b !== 16'd0) begin miss++; $display("FAIL reset_core_ops: got %0d/%0d expected 0/0", core_a, core_b); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_all_four();
        int exp_g[4];
        exp_g = '{4, 7, 25, 1};
        clear_logs();
        set_ops(0, 12, 8); set_ops(1, 35, 21); set_ops(2, 100, 75); set_ops(3, 17, 5);
        req = 4'b1111;
        run_until_rsp(4, 300);
        vec++; if (rsp_log.size() != 4) begin miss++; $display("FAIL all4_count: got %0d expected 4", rsp_log.size()); end
        pad_logs(4);
        for (int i = 0; i < 4; i++) begin
            vec++; if (ack_log[i] !== (4'b0001 << i)) begin miss++; $display("FAIL all4_ack[%0d]: got %b expected %b", i, ack_log[i], 4'b0001 << i); end
            vec++; if (rsp_log[i] !== (4'b0001 << i)) begin miss++; $display("FAIL all4_rsp[%0d]: got %b expected %b", i, rsp_log[i], 4'b0001 << i); end
            vec++; if (gcd_log[i] !== WD'(exp_g[i])) begin miss++; $display("FAIL all4_gcd[%0d]: got %0d expected %0d", i, gcd_log[i], exp_g[i]); end
            vec++; if (rsp_cyc[i] != done_cyc[i] + 1) begin miss++; $display("FAIL all4_rsp_lat[%0d]: got %0d expected %0d", i, rsp_cyc[i], done_cyc[i] + 1); end
        end
        for (int i = 0; i < 3; i++) begin
            vec++; if (ack_cyc[i+1] != done_cyc[i] + 4) begin miss++; $display("FAIL all4_b2b[%0d]: got %0d expected %0d", i, ack_cyc[i+1], done_cyc[i] + 4); end
        end
        drain();
        vec++; if (start_clash != 0) begin miss++; $display("FAIL all4_start_clash: got %0d expected 0", start_clash); end
        vec++; if (starts != 4) begin miss++; $display("FAIL all4_starts: got %0d expected 4", starts); end
    endtask

    task automatic test_single();
        int t0;
        clear_logs();
        set_ops(0, 48, 18);
        req = 4'b0001;
        t0 = cyc;
        run_until_rsp(1, 100);
        vec++; if (ack_log.size() != 1) begin miss++; $display("FAIL single_ack_count: got %0d expected 1", ack_log.size()); end
        pad_logs(1);
        vec++; if (ack_log[0] !== 4'b0001) begin miss++; $display("FAIL single_ack: got %b expected 0001", ack_log[0]); end
        vec++; if (ack_cyc[0] != t0 + 1) begin miss++; $display("FAIL single_ack_lat: got %0d expected %0d", ack_cyc[0], t0 + 1); end
        vec++; if (start_cyc[0] != t0 + 1) begin miss++; $display("FAIL single_start_cyc: got %0d expected %0d", start_cyc[0], t0 + 1); end
        vec++; if (sa_log[0] !== 16'd48 || sb_log[0] !== 16'd18) begin miss++; $display("FAIL single_core_ops: got %0d/%0d expected 48/18", sa_log[0], sb_log[0]); end
        vec++; if (rsp_log[0] !== 4'b0001) begin miss++; $display("FAIL single_rsp: got %b expected 0001", rsp_log[0]); end
        vec++; if (gcd_log[0] !== 16'd6) begin miss++; $display("FAIL single_gcd: got %0d expected 6", gcd_log[0]); end
        drain();
        vec++; if (busy !== 1'b0) begin miss++; $display("FAIL single_busy_end: got %b expected 0", busy); end
        vec++; if (starts != 1) begin miss++; $display("FAIL single_starts: got %0d expected 1", starts); end
        vec++; if (rsp_gcd !== 16'd6 || rsp_valid !== 4'b0000) begin miss++; $display("FAIL single_hold: got %0d/%b expected 6/0000", rsp_gcd, rsp_valid); end
    endtask

    task automatic test_rotation();
        clear_logs();
        set_ops(2, 81, 27);
        req = 4'b0100;
        run_until_rsp(1, 100);
        pad_logs(1);
        vec++; if (gcd_log[0] !== 16'd27) begin miss++; $display("FAIL rot_first_gcd: got %0d expected 27", gcd_log[0]); end
        drain();
        clear_logs();
        set_ops(3, 14, 21); set_ops(0, 9, 6);
        req = 4'b1001;
        run_until_rsp(2, 200);
        pad_logs(2);
        vec++; if (ack_log[0] !== 4'b1000 || ack_log[1] !== 4'b0001) begin miss++; $display("FAIL rot_order: got %b,%b expected 1000,0001", ack_log[0], ack_log[1]); end
        vec++; if (gcd_log[0] !== 16'd7 || gcd_log[1] !== 16'd3) begin miss++; $display("FAIL rot_gcd: got %0d,%0d expected 7,3", gcd_log[0], gcd_log[1]); end
        drain();
    endtask

    task automatic test_zero_operand();
        clear_logs();
        set_ops(1, 0, 7);
        req = 4'b0010;
        run_until_rsp(1, 100);
        pad_logs(1);
        vec++; if (rsp_log[0] !== 4'b0010) begin miss++; $display("FAIL zero_rsp: got %b expected 0010", rsp_log[0]); end
        vec++; if (gcd_log[0] !== 16'd7) begin miss++; $display("FAIL zero_a_gcd: got %0d expected 7", gcd_log[0]); end
        drain();
        clear_logs();
        set_ops(1, 0, 0);
        req = 4'b0010;
        run_until_rsp(1, 100);
        pad_logs(1);
        vec++; if (gcd_log[0] !== 16'd0) begin miss++; $display("FAIL zero_both_gcd: got %0d expected 0", gcd_log[0]); end
        drain();
    endtask

    task automatic test_withdrawal();
        clear_logs();
        set_ops(2, 9, 6);
        req = 4'b0100;
        run_until_ack(1, 50);
        tick(); tick();
        vec++; if (busy !== 1'b1) begin miss++; $display("FAIL wd_busy: got %b expected 1", busy); end
        req[0] = 1'b1;
        tick();
        req[0] = 1'b0;
        run_until_rsp(1, 100);
        drain();
        repeat (6) tick();
        vec++; if (ack_log.size() != 1 || rsp_log.size() != 1) begin miss++; $display("FAIL wd_counts: got %0d/%0d expected 1/1", ack_log.size(), rsp_log.size()); end
        pad_logs(1);
        vec++; if (ack_log[0] !== 4'b0100 || rsp_log[0] !== 4'b0100) begin miss++; $display("FAIL wd_masks: got %b/%b expected 0100/0100", ack_log[0], rsp_log[0]); end
        vec++; if (gcd_log[0] !== 16'd3) begin miss++; $display("FAIL wd_gcd: got %0d expected 3", gcd_log[0]); end
    endtask

    task automatic test_continuous();
        logic [N-1:0] exp_m[8];
        exp_m = '{4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100};
        clear_logs();
        hold_req = 1'b1;
        req = 4'b1111;
        run_until_rsp(8, 500);
        req = 4'b0000;
        hold_req = 1'b0;
        drain();
        repeat (4) tick();
        vec++; if (ack_log.size() != 8) begin miss++; $display("FAIL cont_count: got %0d expected 8", ack_log.size()); end
        pad_logs(8);
        for (int i = 0; i < 8; i++) begin
            vec++; if (ack_log[i] !== exp_m[i] || rsp_log[i] !== exp_m[i]) begin miss++; $display("FAIL cont_grant[%0d]: got %b/%b expected %b", i, ack_log[i], rsp_log[i], exp_m[i]); end
        end
        vec++; if (start_clash != 0) begin miss++; $display("FAIL cont_start_clash: got %0d expected 0", start_clash); end
    endtask

    task automatic test_reset_mid();
        clear_logs();
        set_ops(2, 30, 12);
        req = 4'b0100;
        run_until_ack(1, 50);
        tick();
        rst_n = 1'b0;
        tick();
        vec++; if (ack !== 4'b0000 || rsp_valid !== 4'b0000) begin miss++; $display("FAIL rmid_pulses: got %b/%b expected 0000/0000", ack, rsp_valid); end
        vec++; if (busy !== 1'b0 || core_start !== 1'b0) begin miss++; $display("FAIL rmid_busy_start: got %b/%b expected 0/0", busy, core_start); end
        vec++; if (rsp_gcd !== 16'd0 || core_a !== 16'd0 || core_b !== 16'd0) begin miss++; $display("FAIL rmid_data: got %0d/%0d/%0d expected 0/0/0", rsp_gcd, core_a, core_b); end
        rst_n = 1'b1;
        repeat (12) tick();
        vec++; if (rsp_log.size() != 0) begin miss++; $display("FAIL rmid_no_rsp: got %0d expected 0", rsp_log.size()); end
        clear_logs();
        set_ops(3, 14, 21);
        req = 4'b1100;
        run_until_rsp(2, 200);
        pad_logs(2);
        vec++; if (ack_log[0] !== 4'b0100 || ack_log[1] !== 4'b1000) begin miss++; $display("FAIL rmid_order: got %b,%b expected 0100,1000", ack_log[0], ack_log[1]); end
        vec++; if (gcd_log[0] !== 16'd6 || gcd_log[1] !== 16'd7) begin miss++; $display("FAIL rmid_gcd: got %0d,%0d expected 6,7", gcd_log[0], gcd_log[1]); end
        drain();
    endtask

    initial begin
        test_reset();
        test_all_four();
        test_single();
        test_rotation();
        test_zero_operand();
        test_withdrawal();
        test_continuous();
        test_reset_mid();
        vec++; if (proto_err != 0) begin miss++; $display("FAIL onehot_overlap: got %0d expected 0", proto_err); end
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule

// File: doc/gcd_arbiter.md
# gcd_arbiter

- Round-robin arbiter and sequencer that shares one GCD datapath core among `N_REQ` requesters.
- Each requester presents an operand pair. The arbiter grants one requester at a time, latches its operands, starts the core, waits for the result, and returns the result with a one-hot response pulse.
- Sits between the requester-side logic and the single GCD core instance at top level.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `W`, default 16: operand/result width.
- `clk`  in  1  clock, all logic on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `req`  in  N_REQ  per-requester request level.
- `req_a`  in  N_REQ*W  operand A; requester i uses bits [i*W +: W].
- `req_b`  in  N_REQ*W  operand B, same packing.
- `ack`  out  N_REQ  one-hot, one-cycle pulse: request accepted and operands latched.
- `rsp_valid`  out  N_REQ  one-hot, one-cycle pulse: `rsp_gcd` valid for that requester.
- `rsp_gcd`  out  W  result; holds the last result until the next response.
- `busy`  out  1  high in every state except IDLE.
- `core_start`  out  1  start to the GCD core.
- `core_a`, `core_b`  out  W each  operands to the core; stable from ISSUE until return to IDLE.
- `core_done`  in  1  core done. Held high 2 consecutive cycles per operation. The core accepts `start` only after `done` has dropped.
- `core_gcd`  in  W  core result, valid while `core_done` is high.

## Operation
- Registers:
  - `ptr`: priority pointer, width clog2(N_REQ).
  - `g`: granted index.
  - `op_a`, `op_b`: latched operands.
  - `state`.
- States and transitions:
  - **IDLE**: if `req` != 0, scan indices `ptr`, `ptr+1`, … mod N_REQ and pick the first set bit as `g`. Latch `req_a[g]`, `req_b[g]`. Register `ack[g]`=1 and go to ISSUE. If `req` == 0, stay.
  - **ISSUE**: `core_start`=1 for exactly this cycle. Go to WAIT_DONE.
  - **WAIT_DONE**: on the first cycle `core_done`=1, capture `core_gcd` into `rsp_gcd`, register `rsp_valid[g]`=1 and go to WAIT_DROP. Otherwise stay.
  - **WAIT_DROP**: when `core_done`=0, set `ptr` <= (`g`+1) mod N_REQ and go to IDLE. Otherwise stay.
- `req` is sampled only in IDLE. `req` changes in other states are ignored.
- Request protocol:
  - A requester holds `req` and its operands stable until it sees `ack`.
  - Dropping `req` before `ack` withdraws the request, with no ack and no response.
  - `req` still high after the response is treated as a new request and competes normally.
- Only one operation is outstanding at a time; no queuing.
- `core_done` seen outside WAIT_DONE/WAIT_DROP is ignored.
- Arithmetic: the arbiter does not modify operands or the result. Zero operands pass through, and the core's result is returned as-is.
- Reset (`rst_n`=0 at a rising edge), in any state including mid-operation:
  - State goes to IDLE; `ptr`=0.
  - `ack`, `rsp_valid`, `core_start`, `busy` = 0; `rsp_gcd`, `core_a`, `core_b` = 0.
  - An in-flight request is discarded with no response.
  - The top level resets the core in the same cycle; the arbiter does not reset the core.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- `req` sampled at edge T (IDLE):
  - `ack` and `core_start` are high in cycle T+1.
  - The core samples `start` at the end of T+1.
- `core_done` first high in cycle D:
  - `rsp_valid` and `rsp_gcd` update in D+1.
  - The arbiter reaches IDLE at the earliest at D+3, after `done` drops at D+2.
  - The next grant's `ack` appears at the earliest at D+4.
- Back-to-back overhead per grant, excluding core compute: 4 cycles.
- `ack` and `rsp_valid` are never high for the same requester in the same cycle. At most one bit of each is set.
- If `req`=all-ones continuously, grants rotate strictly 0, 1, 2, 3, 0, … (with `N_REQ`=4). No requester waits more than N_REQ-1 other grants.

## Test plan
- Single request: `req`=0001, a=48, b=18. Expected: `ack`=0001 one cycle, one `core_start` pulse, `rsp_valid`=0001 with `rsp_gcd`=6, `busy` back to 0.
- All four request at once: operand pairs (12,8), (35,21), (100,75), (17,5). Expected: responses in order 0, 1, 2, 3 with `rsp_gcd` = 4, 7, 25, 1. No overlap of `core_start` with an active operation.
- Rotation: serve requester 2 alone, then assert `req`=1001. Expected: requester 3 granted before requester 0.
- Zero operand: a=0, b=7 from requester 1. Expected: `rsp_valid`=0010, `rsp_gcd`=7. Also a=0, b=0 gives `rsp_gcd`=0.
- Withdrawal and late request: requester 0 pulses `req` for one cycle while `busy`=1, then drops it. Expected: no `ack` or `rsp_valid` for requester 0.
- Reset mid-operation: assert `rst_n`=0 during WAIT_DONE. Expected: next cycle all outputs 0 and `busy`=0. No `rsp_valid` for the aborted request. A new request after reset completes correctly.
